// File: rtl/sprite_pkg.sv
// sprite_pkg: definitions shared across the sprite blitter.
//   state_t    - blitter FSM states
//   FB_W/FB_H  - frame buffer dimensions in pixels
//   FB_AW      - frame buffer address width
//   on_screen  - signed test of whether a 12-bit screen coordinate lies
//                inside the frame buffer
package sprite_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int FB_W  = 320;
  localparam int FB_H  = 240;
  localparam int FB_AW = 17;

  // Coordinates are two's complement, so anything left of or above the
  // screen is negative and fails the lower bound.
  function automatic logic on_screen(input logic signed [11:0] x,
                                     input logic signed [11:0] y);
    return (int'(x) >= 0) && (int'(x) < FB_W) &&
           (int'(y) >= 0) && (int'(y) < FB_H);
  endfunction

endpackage

// File: rtl/sprite_blit_addr_gen.sv
// sprite_blit_addr_gen: walks the sprite in raster order and forms the ROM
// read address, applying horizontal mirroring.
//   vga_clk     - clock, rising edge
//   reset       - synchronous, active-high
//   load        - restart at (0,0) and capture flip_in
//   flip_in     - mirror request, captured on load
//   advance     - step to the next sprite pixel
//   sx, sy      - sprite coordinates of the pixel currently being issued
//   last        - current pixel is the final one of the sprite
//   rom_address - ROM address of the current pixel
module sprite_blit_addr_gen #(
  parameter int SPR_W  = 70,
  parameter int SPR_H  = 160,
  parameter int SPR_AW = 14,
  parameter int SX_W   = $clog2(SPR_W),
  parameter int SY_W   = $clog2(SPR_H)
) (
  input  logic              vga_clk,
  input  logic              reset,
  input  logic              load,
  input  logic              flip_in,
  input  logic              advance,
  output logic [SX_W-1:0]   sx,
  output logic [SY_W-1:0]   sy,
  output logic              last,
  output logic [SPR_AW-1:0] rom_address
);

  logic              flip;
  // Running sy*SPR_W, so no multiplier is needed in the address path.
  logic [SPR_AW-1:0] row_base;
  logic [SX_W-1:0]   col;

  wire x_end = (sx == SX_W'(SPR_W - 1));
  wire y_end = (sy == SY_W'(SPR_H - 1));

  // NOTE: state registers use non-blocking assignments so every flop in the
  // design samples the pre-edge values of its neighbours.
  always_ff @(posedge vga_clk) begin
    if (reset) begin
      sx       <= '0;
      sy       <= '0;
      row_base <= '0;
      flip     <= 1'b0;
    end else if (load) begin
      sx       <= '0;
      sy       <= '0;
      row_base <= '0;
      flip     <= flip_in;
    end else if (advance) begin
      if (x_end) begin
        sx <= '0;
        if (y_end) begin
          sy       <= '0;
          row_base <= '0;
        end else begin
          sy       <= sy + SY_W'(1);
          row_base <= row_base + SPR_AW'(SPR_W);
        end
      end else begin
        sx <= sx + SX_W'(1);
      end
    end
  end

  assign col         = flip ? (SX_W'(SPR_W - 1) - sx) : sx;
  assign rom_address = row_base + SPR_AW'(col);
  assign last        = x_end && y_end;

endmodule

// File: rtl/sprite_blitter.sv
// sprite_blitter: copies a palette-indexed sprite from an external ROM into
// the frame buffer at (pos_x, pos_y), skipping transparent pixels, clipping
// at the screen edges and optionally mirroring horizontally.
//   vga_clk     - clock, rising edge
//   reset       - synchronous, active-high
//   start       - one-cycle blit request, honoured only when idle
//   pos_x/pos_y - signed screen position of the sprite's top-left corner
//   flip_x      - mirror the sprite horizontally
//   busy        - blit in progress
//   done        - one-cycle pulse when a blit completes
//   rom_address - sprite ROM read address (ROM has one-cycle latency)
//   rom_q       - sprite ROM read data
//   fb_we/fb_waddr/fb_wdata - frame buffer write port, one write per cycle
module sprite_blitter
  import sprite_pkg::*;
#(
  parameter int SPR_W           = 70,
  parameter int SPR_H           = 160,
  parameter int IDX_W           = 3,
  parameter int SPR_AW          = 14,
  parameter int TRANSPARENT_IDX = 0
) (
  input  logic              vga_clk,
  input  logic              reset,
  input  logic              start,
  input  logic [10:0]       pos_x,
  input  logic [10:0]       pos_y,
  input  logic              flip_x,
  output logic              busy,
  output logic              done,
  output logic [SPR_AW-1:0] rom_address,
  input  logic [IDX_W-1:0]  rom_q,
  output logic              fb_we,
  output logic [FB_AW-1:0]  fb_waddr,
  output logic [IDX_W-1:0]  fb_wdata
);

  localparam int SX_W = $clog2(SPR_W);
  localparam int SY_W = $clog2(SPR_H);

  state_t      state;
  logic        drain_cnt;
  logic [10:0] pos_x_q;
  logic [10:0] pos_y_q;

  logic            load;
  logic            advance;
  logic            last;
  logic [SX_W-1:0] sx;
  logic [SY_W-1:0] sy;

  // Stage 1: coordinates of the pixel whose ROM read is in flight.
  logic            s1_valid;
  logic [SX_W-1:0] s1_sx;
  logic [SY_W-1:0] s1_sy;

  logic signed [11:0] x_scr;
  logic signed [11:0] y_scr;
  logic [FB_AW-1:0]   lin_addr;

  assign load    = (state == IDLE) && start;
  assign advance = (state == RUN);

  sprite_blit_addr_gen #(
    .SPR_W  (SPR_W),
    .SPR_H  (SPR_H),
    .SPR_AW (SPR_AW),
    .SX_W   (SX_W),
    .SY_W   (SY_W)
  ) u_addr_gen (
    .vga_clk     (vga_clk),
    .reset       (reset),
    .load        (load),
    .flip_in     (flip_x),
    .advance     (advance),
    .sx          (sx),
    .sy          (sy),
    .last        (last),
    .rom_address (rom_address)
  );

  // Control FSM. DRAIN covers the two pipeline stages behind the last issue;
  // DONE then raises done and drops busy on the same edge.
  always_ff @(posedge vga_clk) begin
    if (reset) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      drain_cnt <= 1'b0;
      pos_x_q   <= '0;
      pos_y_q   <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            pos_x_q <= pos_x;
            pos_y_q <= pos_y;
            busy    <= 1'b1;
            state   <= RUN;
          end
        end
        RUN: begin
          if (last) begin
            drain_cnt <= 1'b0;
            state     <= DRAIN;
          end
        end
        DRAIN: begin
          if (drain_cnt) state <= DONE;
          else           drain_cnt <= 1'b1;
        end
        DONE: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Stage 1 travels alongside the ROM read, so rom_q and s1_* line up.
  always_ff @(posedge vga_clk) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s1_sx    <= '0;
      s1_sy    <= '0;
    end else begin
      s1_valid <= advance;
      s1_sx    <= sx;
      s1_sy    <= sy;
    end
  end

  // 12-bit two's complement screen coordinates: sign-extended position plus
  // zero-extended sprite offset.
  assign x_scr = {pos_x_q[10], pos_x_q} + {{(12 - SX_W){1'b0}}, s1_sx};
  assign y_scr = {pos_y_q[10], pos_y_q} + {{(12 - SY_W){1'b0}}, s1_sy};

  // Only the low FB_AW bits of Y*FB_W+X are kept; the value matters only
  // when the pixel is on screen, where it always fits.
  assign lin_addr = FB_AW'(y_scr) * FB_AW'(FB_W) + FB_AW'(x_scr);

  // Stage 2: registered frame buffer write.
  always_ff @(posedge vga_clk) begin
    if (reset) begin
      fb_we    <= 1'b0;
      fb_waddr <= '0;
      fb_wdata <= '0;
    end else begin
      fb_we    <= s1_valid && on_screen(x_scr, y_scr) &&
                  (rom_q != IDX_W'(TRANSPARENT_IDX));
      fb_waddr <= lin_addr;
      fb_wdata <= rom_q;
    end
  end

endmodule

// File: tb/tb_sprite_blitter.sv
// tb_sprite_blitter: table-driven back-to-back blits against a scoreboard of
// expected frame buffer writes, plus handshake and mid-blit reset sequences.
module tb_sprite_blitter;

  localparam int SPR_W    = 70;
  localparam int SPR_H    = 160;
  localparam int BLIT_CYC = 11203;

  logic        vga_clk = 1'b0;
  logic        reset;
  logic        start;
  logic [10:0] pos_x;
  logic [10:0] pos_y;
  logic        flip_x;
  logic        busy;
  logic        done;
  logic [13:0] rom_address;
  logic [2:0]  rom_q = 3'd0;
  logic        fb_we;
  logic [16:0] fb_waddr;
  logic [2:0]  fb_wdata;

  always #5 vga_clk = ~vga_clk;

  int cyc = 0;
  always @(posedge vga_clk) cyc <= cyc + 1;

  // ROM contents selected per test: 0 = never zero, 1 = zero at even
  // columns, 2 = column mod 8.
  function automatic logic [2:0] rom_data(input int mode, input logic [13:0] addr);
    int a;
    int col;
    a   = int'(addr);
    col = a % SPR_W;
    case (mode)
      0:       return 3'((a % 7) + 1);
      1:       return (col % 2 == 0) ? 3'd0 : 3'(((a / SPR_W) % 7) + 1);
      default: return 3'(col % 8);
    endcase
  endfunction

  int rom_mode = 0;
  always @(posedge vga_clk) rom_q <= rom_data(rom_mode, rom_address);

  sprite_blitter dut (
    .vga_clk     (vga_clk),
    .reset       (reset),
    .start       (start),
    .pos_x       (pos_x),
    .pos_y       (pos_y),
    .flip_x      (flip_x),
    .busy        (busy),
    .done        (done),
    .rom_address (rom_address),
    .rom_q       (rom_q),
    .fb_we       (fb_we),
    .fb_waddr    (fb_waddr),
    .fb_wdata    (fb_wdata)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard of expected writes, packed as {waddr, wdata}.
  longint sb[$];
  int     n_writes;
  int     n_done;
  int     even_cols;
  int     first_a, first_d, last_a;

  task automatic load_model(input int px, input int py, input bit flip, input int mode);
    sb.delete();
    for (int y = 0; y < SPR_H; y++) begin
      for (int x = 0; x < SPR_W; x++) begin
        int          col;
        int          sx_scr;
        int          sy_scr;
        logic [2:0]  d;
        col    = flip ? (SPR_W - 1 - x) : x;
        d      = rom_data(mode, 14'(y * SPR_W + col));
        sx_scr = px + x;
        sy_scr = py + y;
        if (sx_scr >= 0 && sx_scr < 320 && sy_scr >= 0 && sy_scr < 240 && d != 3'd0)
          sb.push_back(longint'({17'(sy_scr * 320 + sx_scr), d}));
      end
    end
  endtask

  task automatic clear_stats();
    n_writes  = 0;
    n_done    = 0;
    even_cols = 0;
    first_a   = -1;
    first_d   = -1;
    last_a    = -1;
  endtask

  // Advance to the next falling edge and score whatever the DUT produced.
  task automatic tick();
    @(negedge vga_clk);
    if (fb_we === 1'b1) begin
      check("sb_pending", longint'(sb.size() > 0), 1);
      if (sb.size() > 0)
        check("sb_write", longint'({fb_waddr, fb_wdata}), sb.pop_front());
      if (n_writes == 0) begin
        first_a = int'(fb_waddr);
        first_d = int'(fb_wdata);
      end
      last_a = int'(fb_waddr);
      if ((int'(fb_waddr) % 320) % 2 == 0) even_cols++;
      n_writes++;
    end
    if (done === 1'b1) n_done++;
  endtask

  typedef struct {
    int px;
    int py;
    bit flip;
    int mode;
    int exp_writes;
    int exp_first_a;
    int exp_first_d;
    int exp_last_a;
  } vec_t;

  vec_t vecs[6];

  task automatic run_blit(input int i);
    vec_t v;
    int   accept;
    bit   got;
    v        = vecs[i];
    rom_mode = v.mode;
    load_model(v.px, v.py, v.flip, v.mode);
    clear_stats();
    pos_x  = 11'(v.px);
    pos_y  = 11'(v.py);
    flip_x = v.flip;
    start  = 1'b1;
    tick();
    start  = 1'b0;
    accept = cyc;
    check("busy_after_accept", longint'(busy), 1);
    // Latched copies must be used from here on.
    pos_x  = 11'($urandom);
    pos_y  = 11'($urandom);
    flip_x = ~flip_x;
    got = 1'b0;
    for (int t = 1; t <= BLIT_CYC + 20 && !got; t++) begin
      // On the first blit, starts sampled at edges 5 and 11202 must be ignored.
      start = (i == 0 && (t == 5 || t == 11202));
      if (start) pos_x = 11'($urandom);
      tick();
      if (done === 1'b1) begin
        got = 1'b1;
        check("done_latency", longint'(cyc - accept), BLIT_CYC);
        check("busy_at_done", longint'(busy), 0);
      end
    end
    start = 1'b0;
    check("done_seen", longint'(got), 1);
    check("write_count", n_writes, v.exp_writes);
    check("done_count", n_done, 1);
    check("sb_left", sb.size(), 0);
    if (v.exp_writes > 0) begin
      check("first_waddr", first_a, v.exp_first_a);
      check("first_wdata", first_d, v.exp_first_d);
      check("last_waddr", last_a, v.exp_last_a);
    end
    if (v.mode == 1) check("even_col_writes", even_cols, 0);
  endtask

  initial begin
    reset  = 1'b1;
    start  = 1'b0;
    pos_x  = '0;
    pos_y  = '0;
    flip_x = 1'b0;
    clear_stats();
    tick();
    tick();
    check("reset_busy", longint'(busy), 0);
    check("reset_done", longint'(done), 0);
    check("reset_fb_we", longint'(fb_we), 0);
    check("reset_rom_address", longint'(rom_address), 0);
    check("reset_fb_waddr", longint'(fb_waddr), 0);
    check("reset_fb_wdata", longint'(fb_wdata), 0);
    reset = 1'b0;
    tick();

    //          px    py  flip mode writes first_a first_d last_a
    vecs[0] = '{   0,   0, 1'b0, 0, 11200,     0,     1, 50949};
    vecs[1] = '{   0,   0, 1'b0, 1,  5600,     1,     1, 50949};
    vecs[2] = '{ -10,   0, 1'b0, 0,  9600,     0,     4, 50939};
    vecs[3] = '{ 300, 200, 1'b0, 0,   800, 64300,     1, 76799};
    vecs[4] = '{   0,   0, 1'b1, 2,  9760,     0,     5, 50948};
    vecs[5] = '{-100, 300, 1'b0, 0,     0,     0,     0,     0};

    // Each blit starts on the edge right after the previous done pulse.
    for (int i = 0; i < 6; i++) run_blit(i);

    clear_stats();
    repeat (5) tick();
    check("idle_writes", n_writes, 0);
    check("idle_done", n_done, 0);

    // Reset asserted mid-blit: outputs clear on that edge and stay quiet.
    rom_mode = 0;
    load_model(0, 0, 1'b0, 0);
    clear_stats();
    pos_x = '0;
    pos_y = '0;
    flip_x = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (2999) tick();
    check("pre_reset_writes", n_writes, 2998);
    reset = 1'b1;
    tick();
    check("midreset_fb_we", longint'(fb_we), 0);
    check("midreset_busy", longint'(busy), 0);
    check("midreset_done", longint'(done), 0);
    reset = 1'b0;
    sb.delete();
    clear_stats();
    repeat (200) tick();
    check("post_reset_writes", n_writes, 0);
    check("post_reset_done", n_done, 0);
    check("post_reset_busy", longint'(busy), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
